ann_window_sequencer: RTL and testbench
=======================================

ANN_WINDOW_SEQUENCER -- requirements
Module: ann_window_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 156, width of one temperature sample and of each window slot.
REQ-002 SHALL have parameter INPUT_NUM, default 4, window depth (samples per core request), legal range 2..16.
REQ-003 SHALL have parameter RES_W, default 26, number of core-result LSBs used for the prediction.
REQ-004 SHALL have parameter SCALE, default 1000, constant divisor applied to the core result.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before the core is declared failed.
REQ-006 SHALL have port Clk  input  1  single clock; all logic is rising-edge.
REQ-007 SHALL have port Reset_h  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port Sample_in  input  DATA_W  next daily sample.
REQ-009 SHALL have port Sample_valid_h  input  1  Sample_in is offered this cycle.
REQ-010 SHALL have port Sample_missing_h  input  1  offered sample is absent; qualified by Sample_valid_h.
REQ-011 SHALL have port Sample_ready_h  output  1  block accepts a sample this cycle.
REQ-012 SHALL have port Flush_h  input  1  discard the window and restart filling.
REQ-013 SHALL have port Window_out  output  INPUT_NUM*DATA_W  slot k at bits [(k+1)*DATA_W-1 : k*DATA_W]; slot 0 is the oldest sample.
REQ-014 SHALL have port Core_start_h  output  1  one-cycle request to the ANN core.
REQ-015 SHALL have port Core_done_h  input  1  core result valid.
REQ-016 SHALL have port Core_result  input  DATA_W  raw core output.
REQ-017 SHALL have port Prediction_out  output  DATA_W  last scaled prediction.
REQ-018 SHALL have port Prediction_valid_h  output  1  one-cycle pulse marking a new Prediction_out.
REQ-019 SHALL have port Filled_h  output  1  one-cycle pulse marking that a prediction was substituted for a missing sample.
REQ-020 SHALL have port Err  output  1  one-cycle error pulse.
REQ-021 SHALL have port Pred_count  output  16  count of predictions issued; wraps 0xFFFF->0.

Function
REQ-022 SHALL implement the states FILL, START, WAIT, OUT and ACCEPT.
REQ-023 FILL: Sample_ready_h=1; a valid, non-missing sample shifts in (slot0 dropped, new value in slot INPUT_NUM-1) and increments fill count; when count reaches INPUT_NUM the FSM goes to START.
REQ-024 FILL with a valid missing sample: SHALL pulse Err, discard the sample, and leave the count unchanged.
REQ-025 START: Core_start_h=1 for exactly one cycle, then WAIT; Window_out SHALL stay stable from START until the next shift.
REQ-026 WAIT: on Core_done_h=1 SHALL capture Prediction_out = (Core_result[RES_W-1:0] / SCALE), zero-extended to DATA_W, set pred_ok, and go to OUT.
REQ-027 WAIT: if TIMEOUT cycles pass without Core_done_h, SHALL pulse Err, clear pred_ok, and go to ACCEPT; Prediction_out SHALL hold its prior value.
REQ-028 OUT: Prediction_valid_h=1 for one cycle, Pred_count+1, then ACCEPT.
REQ-029 ACCEPT: Sample_ready_h=1; a valid, non-missing sample shifts in and the FSM goes to START.
REQ-030 ACCEPT with a valid missing sample and pred_ok=1: SHALL shift in Prediction_out, pulse Filled_h, and go to START.
REQ-031 ACCEPT with a valid missing sample and pred_ok=0: SHALL pulse Err, change nothing, and stay in ACCEPT.
REQ-032 Sample_ready_h SHALL be 0 in START, WAIT and OUT; samples offered in those states SHALL be ignored.
REQ-033 Core_done_h outside WAIT SHALL be ignored.
REQ-034 Flush_h SHALL take priority in any state: the next state is FILL with count=0, window zeroed and pred_ok=0; a sample offered in the same cycle is dropped; Pred_count and Prediction_out are kept.
REQ-035 Latency: Core_start_h SHALL fire the cycle after the accepting edge; Prediction_valid_h SHALL fire the cycle after Core_done_h is sampled.

Reset
REQ-036 Reset_h=1 at a rising edge SHALL force FILL with count 0, and clear Window_out, Prediction_out, Pred_count and pred_ok.
REQ-037 During reset, Core_start_h, Prediction_valid_h, Filled_h, Err and Sample_ready_h SHALL all be 0; Reset_h SHALL override Flush_h and every other input.

Verification
REQ-038 Reset, then feed 0x1F, 0x20, 0x21, 0x22 -> Core_start_h one cycle after the 4th accept, Window_out = {0x22,0x21,0x20,0x1F}.
REQ-039 In WAIT, Core_done_h with Core_result = 23000 -> Prediction_out = 0x17, one Prediction_valid_h pulse, Pred_count = 1.
REQ-040 Next sample valid and missing -> window becomes {0x17,0x22,0x21,0x20}, Filled_h pulses, Core_start_h follows.
REQ-041 No Core_done_h for 64 cycles -> Err pulse, no Prediction_valid_h; a following missing sample -> Err pulse and Window_out unchanged.
REQ-042 Flush_h and Sample_valid_h in the same cycle during ACCEPT -> state FILL, window 0, sample dropped, Pred_count unchanged.
REQ-043 Reset_h in WAIT, then a late Core_done_h -> all outputs 0 and no Prediction_valid_h.

Source files
------------

// File: rtl/ann_window_sequencer.sv
// Sliding-window sequencer for an ANN temperature predictor: collects samples, starts the core,
// scales its result into a prediction and substitutes that prediction for a missing sample.
module ann_window_sequencer #(
    parameter int DATA_W    = 156,
    parameter int INPUT_NUM = 4,
    parameter int RES_W     = 26,
    parameter int SCALE     = 1000,
    parameter int TIMEOUT   = 64
) (
    input  logic                        Clk,
    input  logic                        Reset_h,
    input  logic [DATA_W-1:0]           Sample_in,
    input  logic                        Sample_valid_h,
    input  logic                        Sample_missing_h,
    output logic                        Sample_ready_h,
    input  logic                        Flush_h,
    output logic [INPUT_NUM*DATA_W-1:0] Window_out,
    output logic                        Core_start_h,
    input  logic                        Core_done_h,
    input  logic [DATA_W-1:0]           Core_result,
    output logic [DATA_W-1:0]           Prediction_out,
    output logic                        Prediction_valid_h,
    output logic                        Filled_h,
    output logic                        Err,
    output logic [15:0]                 Pred_count
);
    localparam int WIN_W = INPUT_NUM * DATA_W;
    localparam int CNT_W = $clog2(INPUT_NUM + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(INPUT_NUM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [RES_W-1:0] SCALE_DIV = RES_W'(SCALE);

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        OUT    = 3'd3,
        ACCEPT = 3'd4
    } state_t;

    // Drops the oldest slot (lowest bits) and places the new value in the newest slot.
    function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] win,
                                                  input logic [DATA_W-1:0] val);
        shift_in = {val, win[WIN_W-1:DATA_W]};
    endfunction

    state_t             state_r, state_nx;
    logic [CNT_W-1:0]   cnt_r, cnt_nx;
    logic [TMO_W-1:0]   wait_r, wait_nx;
    logic [WIN_W-1:0]   win_r, win_nx;
    logic [DATA_W-1:0]  pred_r, pred_nx;
    logic               pred_ok_r, pred_ok_nx;
    logic [15:0]        pcount_r, pcount_nx;
    logic               ready_r, ready_nx;
    logic               start_r, start_nx;
    logic               pvalid_r, pvalid_nx;
    logic               filled_r, filled_nx;
    logic               err_r, err_nx;
    logic               take_s;
    logic [RES_W-1:0]   quot_s;
    logic [DATA_W-1:0]  scaled_s;

    generate
        if (DATA_W > RES_W) begin : g_unused_hi
            logic unused_result_hi_s;
            assign unused_result_hi_s = ^Core_result[DATA_W-1:RES_W];
        end
    endgenerate

    // Scaled prediction taken from the low result bits, zero-extended to a sample width.
    always_comb begin
        quot_s   = Core_result[RES_W-1:0] / SCALE_DIV;
        scaled_s = DATA_W'(quot_s);
        take_s   = Sample_valid_h & ready_r;
    end

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        wait_nx    = wait_r;
        win_nx     = win_r;
        pred_nx    = pred_r;
        pred_ok_nx = pred_ok_r;
        pcount_nx  = pcount_r;
        filled_nx  = 1'b0;
        err_nx     = 1'b0;
        if (Flush_h) begin
            state_nx   = FILL;
            cnt_nx     = {CNT_W{1'b0}};
            win_nx     = {WIN_W{1'b0}};
            pred_ok_nx = 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (take_s && Sample_missing_h) begin
                        err_nx = 1'b1;
                    end else if (take_s) begin
                        win_nx = shift_in(win_r, Sample_in);
                        cnt_nx = cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_FILL) begin
                            state_nx = START;
                        end else begin
                            state_nx = FILL;
                        end
                    end else begin
                        state_nx = FILL;
                    end
                end
                START: begin
                    state_nx = WAIT;
                    wait_nx  = {TMO_W{1'b0}};
                end
                WAIT: begin
                    // A done arriving on the final allowed cycle still wins over the timeout.
                    if (Core_done_h) begin
                        pred_nx    = scaled_s;
                        pred_ok_nx = 1'b1;
                        pcount_nx  = pcount_r + 16'd1;
                        state_nx   = OUT;
                    end else if (wait_r == TMO_LAST) begin
                        err_nx     = 1'b1;
                        pred_ok_nx = 1'b0;
                        state_nx   = ACCEPT;
                    end else begin
                        wait_nx = wait_r + TMO_W'(1);
                    end
                end
                OUT: begin
                    state_nx = ACCEPT;
                end
                ACCEPT: begin
                    if (take_s && !Sample_missing_h) begin
                        win_nx   = shift_in(win_r, Sample_in);
                        state_nx = START;
                    end else if (take_s && pred_ok_r) begin
                        win_nx    = shift_in(win_r, pred_r);
                        filled_nx = 1'b1;
                        state_nx  = START;
                    end else if (take_s) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = ACCEPT;
                    end
                end
                default: begin
                    state_nx = FILL;
                end
            endcase
        end
        start_nx  = (state_nx == START);
        pvalid_nx = (state_nx == OUT);
        ready_nx  = (state_nx == FILL) || (state_nx == ACCEPT);
    end

    // State, datapath and registered output flags; reset overrides every input.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_r   <= FILL;
            cnt_r     <= {CNT_W{1'b0}};
            wait_r    <= {TMO_W{1'b0}};
            win_r     <= {WIN_W{1'b0}};
            pred_r    <= {DATA_W{1'b0}};
            pred_ok_r <= 1'b0;
            pcount_r  <= 16'd0;
            ready_r   <= 1'b0;
            start_r   <= 1'b0;
            pvalid_r  <= 1'b0;
            filled_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            wait_r    <= wait_nx;
            win_r     <= win_nx;
            pred_r    <= pred_nx;
            pred_ok_r <= pred_ok_nx;
            pcount_r  <= pcount_nx;
            ready_r   <= ready_nx;
            start_r   <= start_nx;
            pvalid_r  <= pvalid_nx;
            filled_r  <= filled_nx;
            err_r     <= err_nx;
        end
    end

    assign Sample_ready_h     = ready_r;
    assign Window_out         = win_r;
    assign Core_start_h       = start_r;
    assign Prediction_out     = pred_r;
    assign Prediction_valid_h = pvalid_r;
    assign Filled_h           = filled_r;
    assign Err                = err_r;
    assign Pred_count         = pcount_r;

endmodule

// File: tb/tb_ann_window_sequencer.sv
// Scoreboard bench for ann_window_sequencer: a queue-based window model predicts every
// core request, prediction, fill and error pulse; a negedge monitor pops and compares.
module tb_ann_window_sequencer;
    localparam int DATA_W    = 156;
    localparam int INPUT_NUM = 4;
    localparam int RES_W     = 26;
    localparam int SCALE     = 1000;
    localparam int TIMEOUT   = 64;
    localparam int WIN_W     = INPUT_NUM * DATA_W;

    logic              Clk = 1'b0;
    logic              Reset_h, Sample_valid_h, Sample_missing_h, Flush_h, Core_done_h;
    logic [DATA_W-1:0] Sample_in, Core_result;
    logic              Sample_ready_h, Core_start_h, Prediction_valid_h, Filled_h, Err;
    logic [WIN_W-1:0]  Window_out;
    logic [DATA_W-1:0] Prediction_out;
    logic [15:0]       Pred_count;

    always #5 Clk = ~Clk;

    ann_window_sequencer #(.DATA_W(DATA_W), .INPUT_NUM(INPUT_NUM), .RES_W(RES_W),
                           .SCALE(SCALE), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_h(Reset_h), .Sample_in(Sample_in), .Sample_valid_h(Sample_valid_h),
        .Sample_missing_h(Sample_missing_h), .Sample_ready_h(Sample_ready_h), .Flush_h(Flush_h),
        .Window_out(Window_out), .Core_start_h(Core_start_h), .Core_done_h(Core_done_h),
        .Core_result(Core_result), .Prediction_out(Prediction_out),
        .Prediction_valid_h(Prediction_valid_h), .Filled_h(Filled_h), .Err(Err),
        .Pred_count(Pred_count)
    );

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [15:0]       cnt;
    } pred_t;

    int                checks = 0;
    int                passes = 0;
    logic [DATA_W-1:0] win_q[$];
    int                fill_n;
    logic [DATA_W-1:0] m_pred;
    bit                m_pred_ok;
    logic [15:0]       m_count;
    logic [WIN_W-1:0]  start_q[$];
    pred_t             pred_q[$];
    int                exp_filled = 0;
    int                exp_err = 0;

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[DATA_W-1:0];
    endfunction

    function automatic logic [WIN_W-1:0] model_window();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int k = 0; k < INPUT_NUM; k++) w[k*DATA_W +: DATA_W] = win_q[k];
        return w;
    endfunction

    task automatic model_push(input logic [DATA_W-1:0] v);
        win_q.push_back(v);
        win_q.delete(0);
    endtask

    task automatic model_clear();
        win_q.delete();
        for (int k = 0; k < INPUT_NUM; k++) win_q.push_back('0);
        fill_n    = 0;
        m_pred_ok = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_pred  = '0;
        m_count = 16'd0;
    endtask

    // Reference behaviour for one accepted sample; returns whether a core request follows.
    task automatic model_accept(input logic [DATA_W-1:0] v, input bit miss, output bit started);
        started = 1'b0;
        if (fill_n < INPUT_NUM) begin
            if (miss) exp_err++;
            else begin
                model_push(v);
                fill_n++;
                started = (fill_n == INPUT_NUM);
            end
        end else if (!miss) begin
            model_push(v);
            started = 1'b1;
        end else if (m_pred_ok) begin
            model_push(m_pred);
            exp_filled++;
            started = 1'b1;
        end else exp_err++;
        if (started) start_q.push_back(model_window());
    endtask

    // Monitor: every output pulse must match the next expectation.
    always @(negedge Clk) begin
        logic [WIN_W-1:0] ew;
        pred_t            pe;
        if (Core_start_h) begin
            if (start_q.size() == 0) begin checks++; $display("FAIL start_pulse: got pulse expected none"); end
            else begin ew = start_q.pop_front(); check("start_window", Window_out, ew); end
        end
        if (Prediction_valid_h) begin
            if (pred_q.size() == 0) begin checks++; $display("FAIL pred_pulse: got pulse expected none"); end
            else begin
                pe = pred_q.pop_front();
                check("pred_value", Prediction_out, pe.val);
                check("pred_count", Pred_count, pe.cnt);
            end
        end
        if (Filled_h) begin
            checks++;
            if (exp_filled > 0) begin passes++; exp_filled--; end
            else $display("FAIL filled_pulse: got pulse expected none");
        end
        if (Err) begin
            checks++;
            if (exp_err > 0) begin passes++; exp_err--; end
            else $display("FAIL err_pulse: got pulse expected none");
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk);
            ok = Sample_ready_h;
        end
        if (!ok) begin checks++; $display("FAIL ready_timeout: got ready 0 expected 1"); end
    endtask

    task automatic offer(input logic [DATA_W-1:0] v, input bit miss, output bit started);
        bit ok;
        started = 1'b0;
        wait_ready(ok);
        if (ok) begin
            Sample_in = v; Sample_missing_h = miss; Sample_valid_h = 1'b1;
            @(posedge Clk);
            model_accept(v, miss, started);
            #1 Sample_valid_h = 1'b0; Sample_missing_h = 1'b0;
        end
    endtask

    task automatic check_zero_outputs();
        check("rst_window", Window_out, '0);
        check("rst_pred", Prediction_out, '0);
        check("rst_count", Pred_count, '0);
        check("rst_flags", {Core_start_h, Prediction_valid_h, Filled_h, Err, Sample_ready_h}, '0);
    endtask

    // Plays the ANN core after a request: 0 answers after d cycles, 1 stays silent, 2 resets mid-wait.
    task automatic serve(input int mode, input logic [DATA_W-1:0] res, input int d);
        int              n;
        longint unsigned raw;
        @(negedge Clk);
        check("start_latency", Core_start_h, 1);
        @(posedge Clk);
        if (mode == 0) begin
            #1 Sample_valid_h = 1'b1; Sample_in = rand_word(); Sample_missing_h = $urandom_range(1);
            for (int i = 0; i < d; i++) begin @(posedge Clk); #1; end
            Core_done_h = 1'b1; Core_result = res;
            raw = longint'(res[RES_W-1:0]);
            m_pred = DATA_W'(raw / SCALE);
            m_pred_ok = 1'b1;
            m_count++;
            pred_q.push_back('{val: m_pred, cnt: m_count});
            @(posedge Clk);
            #1 Core_done_h = 1'b0; Sample_valid_h = 1'b0; Sample_missing_h = 1'b0;
            @(negedge Clk);
            check("pred_latency", Prediction_valid_h, 1);
        end else if (mode == 1) begin
            exp_err++;
            n = 0;
            while (n < 200) begin
                @(negedge Clk);
                n++;
                if (Err) break;
            end
            m_pred_ok = 1'b0;
            check("timeout_cycles", n, TIMEOUT + 1);
            check("timeout_pred_hold", Prediction_out, m_pred);
        end else begin
            #1 Reset_h = 1'b1;
            @(posedge Clk);
            model_reset();
            @(negedge Clk);
            check_zero_outputs();
            Reset_h = 1'b0; Core_done_h = 1'b1; Core_result = res;
            @(negedge Clk);
            Core_done_h = 1'b0;
            @(negedge Clk);
            check("late_done_count", Pred_count, m_count);
        end
    endtask

    task automatic flush_with_sample();
        bit ok;
        wait_ready(ok);
        if (ok) begin
            Flush_h = 1'b1; Sample_valid_h = 1'b1; Sample_missing_h = 1'b0; Sample_in = rand_word();
            @(posedge Clk);
            model_clear();
            #1 Flush_h = 1'b0; Sample_valid_h = 1'b0;
            @(negedge Clk);
            check("flush_window", Window_out, model_window());
            check("flush_count", Pred_count, m_count);
            check("flush_ready", Sample_ready_h, 1);
        end
    endtask

    task automatic stray_done();
        bit ok;
        wait_ready(ok);
        if (ok) begin
            Core_done_h = 1'b1; Core_result = rand_word();
            @(posedge Clk);
            #1 Core_done_h = 1'b0;
            @(negedge Clk);
            check("stray_done_ignored", Prediction_valid_h, 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit               st;
        bit               miss;
        int               r;
        int               m;
        logic [WIN_W-1:0] exp_w;
        Reset_h = 1'b1; Sample_valid_h = 1'b0; Sample_missing_h = 1'b0; Flush_h = 1'b1;
        Core_done_h = 1'b0; Sample_in = '0; Core_result = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_zero_outputs();
        model_reset();
        Reset_h = 1'b0; Flush_h = 1'b0;

        offer(DATA_W'(8'h1F), 1'b0, st);
        offer(DATA_W'(8'h20), 1'b0, st);
        offer(DATA_W'(8'h21), 1'b0, st);
        offer(DATA_W'(8'h22), 1'b0, st);
        exp_w = {DATA_W'(8'h22), DATA_W'(8'h21), DATA_W'(8'h20), DATA_W'(8'h1F)};
        check("first_window", Window_out, exp_w);
        serve(0, DATA_W'(23000), 3);
        check("first_pred", Prediction_out, DATA_W'(8'h17));
        check("first_count", Pred_count, 16'd1);

        offer(rand_word(), 1'b1, st);
        exp_w = {DATA_W'(8'h17), DATA_W'(8'h22), DATA_W'(8'h21), DATA_W'(8'h20)};
        check("filled_window", Window_out, exp_w);
        serve(1, '0, 0);
        offer(rand_word(), 1'b1, st);
        @(negedge Clk);
        check("missing_no_pred_window", Window_out, exp_w);

        offer(rand_word(), 1'b0, st);
        serve(0, rand_word(), 10);
        flush_with_sample();
        stray_done();
        for (int i = 0; i < INPUT_NUM; i++) offer(rand_word(), 1'b0, st);
        serve(2, rand_word(), 0);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(99);
            if (r < 8) flush_with_sample();
            else if (r < 12) stray_done();
            else begin
                miss = ($urandom_range(3) == 0);
                offer(rand_word(), miss, st);
                if (st) begin
                    m = $urandom_range(99);
                    if (m < 75) serve(0, rand_word(), $urandom_range(40));
                    else if (m < 93) serve(1, '0, 0);
                    else serve(2, rand_word(), 0);
                end
            end
        end

        repeat (3) @(negedge Clk);
        check("start_q_drained", start_q.size(), 0);
        check("pred_q_drained", pred_q.size(), 0);
        check("filled_drained", exp_filled, 0);
        check("err_drained", exp_err, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
